// File: rtl/pla_engine_pkg.sv
// Shared constants and term record for the PLA engine.
package pla_engine_pkg;
  localparam int PLA_N_IN   = 8;
  localparam int PLA_N_TERM = 32;
  localparam int PLA_N_OUT  = 16;

  // One product term at the default geometry.
  typedef struct packed {
    logic                 en;
    logic [PLA_N_IN-1:0]  mask;
    logic [PLA_N_IN-1:0]  val;
    logic [PLA_N_OUT-1:0] or_plane;
  } pla_term_t;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pla_term_store.sv
// Term storage for the PLA: enable bits with reset, AND/OR planes without.
// Writes to an address past N_TERM are dropped and raise a sticky error.
module pla_term_store
  import pla_engine_pkg::*;
#(
  parameter int N_IN   = PLA_N_IN,
  parameter int N_TERM = PLA_N_TERM,
  parameter int N_OUT  = PLA_N_OUT,
  parameter int ADDR_W = addr_w(PLA_N_TERM)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_i,
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic                          en_i,
  input  logic [N_IN-1:0]               mask_i,
  input  logic [N_IN-1:0]               val_i,
  input  logic [N_OUT-1:0]              or_i,
  output logic [N_TERM-1:0]             en_o,
  output logic [N_TERM-1:0][N_IN-1:0]   mask_o,
  output logic [N_TERM-1:0][N_IN-1:0]   val_o,
  output logic [N_TERM-1:0][N_OUT-1:0]  or_o,
  output logic                          err_o
);
  localparam int IDX_W = addr_w(N_TERM);

  logic                         in_range;
  logic [IDX_W-1:0]             idx;
  logic [N_TERM-1:0]            en_q;
  logic [N_TERM-1:0][N_IN-1:0]  mask_q, val_q;
  logic [N_TERM-1:0][N_OUT-1:0] or_q;
  logic                         err_q;

  assign in_range = 32'(addr_i) < N_TERM;
  assign idx      = addr_i[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= '0;
      err_q <= 1'b0;
    end else if (wr_i) begin
      if (in_range) en_q[idx] <= en_i;
      else          err_q     <= 1'b1;
    end
  end

  // Planes are only observed through enabled terms, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_i && in_range) begin
      mask_q[idx] <= mask_i;
      val_q[idx]  <= val_i;
      or_q[idx]   <= or_i;
    end
  end

  assign en_o   = en_q;
  assign mask_o = mask_q;
  assign val_o  = val_q;
  assign or_o   = or_q;
  assign err_o  = err_q;
endmodule

// File: rtl/pla_engine.sv
// Two-stage programmable logic array: AND plane registered in stage 1, OR plane in stage 2.
// Optional PLA_ENGINE_PARITY_EN adds z_par, the registered XOR of z.
module pla_engine
  import pla_engine_pkg::*;
#(
  parameter int N_IN   = PLA_N_IN,
  parameter int N_TERM = PLA_N_TERM,
  parameter int N_OUT  = PLA_N_OUT,
  parameter int ADDR_W = addr_w(N_TERM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic              cfg_en,
  input  logic [N_IN-1:0]   cfg_mask,
  input  logic [N_IN-1:0]   cfg_val,
  input  logic [N_OUT-1:0]  cfg_or,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   x,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PLA_ENGINE_PARITY_EN
  output logic              z_par,
`endif
  output logic [N_OUT-1:0]  z
);
  logic                         cfg_fire, in_fire, s1_free, s2_free;
  logic [N_TERM-1:0]            en;
  logic [N_TERM-1:0][N_IN-1:0]  mask, val;
  logic [N_TERM-1:0][N_OUT-1:0] orp;

  logic                 v1_q, v1_d, ov_q, ov_d;
  logic [N_TERM-1:0]    act_q, act_d, act_new;
  logic [N_OUT-1:0]     z_q, z_d, z_new;

  pla_term_store #(.N_IN(N_IN), .N_TERM(N_TERM), .N_OUT(N_OUT), .ADDR_W(ADDR_W)) u_store (
    .clk(clk), .rst(rst), .wr_i(cfg_fire), .addr_i(cfg_addr),
    .en_i(cfg_en), .mask_i(cfg_mask), .val_i(cfg_val), .or_i(cfg_or),
    .en_o(en), .mask_o(mask), .val_o(val), .or_o(orp), .err_o(cfg_err)
  );

  // Config only lands on an empty pipeline, so both planes are stable for every in-flight vector.
  assign cfg_ready = !v1_q && !ov_q;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign s2_free   = !ov_q || out_ready;
  assign s1_free   = !v1_q || s2_free;
  assign in_ready  = s1_free && !cfg_fire;
  assign in_fire   = in_valid && in_ready;

  always_comb begin
    act_new = '0;
    z_new   = '0;
    for (int t = 0; t < N_TERM; t++) begin
      act_new[t] = en[t] && ((x & mask[t]) == (val[t] & mask[t]));
      if (act_q[t]) z_new = z_new | orp[t];
    end
  end

  always_comb begin
    v1_d  = v1_q;
    act_d = act_q;
    ov_d  = ov_q;
    z_d   = z_q;
    if (s1_free) begin
      v1_d = in_fire;
      if (in_fire) act_d = act_new;
    end
    if (s2_free) begin
      ov_d = v1_q;
      if (v1_q) z_d = z_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      ov_q <= 1'b0;
      z_q  <= '0;
    end else begin
      v1_q <= v1_d;
      ov_q <= ov_d;
      z_q  <= z_d;
    end
  end

  always_ff @(posedge clk) act_q <= act_d;

  assign out_valid = ov_q;
  assign z         = z_q;

`ifdef PLA_ENGINE_PARITY_EN
  logic zp_q;
  always_ff @(posedge clk) begin
    if (rst)                  zp_q <= 1'b0;
    else if (s2_free && v1_q) zp_q <= ^z_new;
  end
  assign z_par = zp_q;
`endif
endmodule

// File: tb/tb_pla_engine.sv
// Bench for pla_engine: hand vectors, a constant table, and a scoreboard fed by a reference PLA model.
module tb_pla_engine;
  localparam int NI = 8, NT = 32, NO = 16, AW = 6;

  logic          clk = 1'b0, rst = 1'b1;
  logic          cfg_valid = 1'b0, cfg_ready, cfg_en = 1'b0, cfg_err;
  logic [AW-1:0] cfg_addr = '0;
  logic [NI-1:0] cfg_mask = '0, cfg_val = '0, xv = '0;
  logic [NO-1:0] cfg_or = '0, z;
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
`ifdef PLA_ENGINE_PARITY_EN
  logic          z_par;
`endif

  pla_engine #(.N_IN(NI), .N_TERM(NT), .N_OUT(NO), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_en(cfg_en), .cfg_mask(cfg_mask), .cfg_val(cfg_val), .cfg_or(cfg_or), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .x(xv), .out_valid(out_valid), .out_ready(out_ready),
`ifdef PLA_ENGINE_PARITY_EN
    .z_par(z_par),
`endif
    .z(z)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_out = 0;
  logic [15:0] sbq[$];
  logic          m_en[NT];
  logic [NI-1:0] m_mask[NT], m_val[NT];
  logic [NO-1:0] m_or[NT];
  bit rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  function automatic logic [15:0] model(input logic [7:0] v);
    logic [15:0] r = '0;
    for (int t = 0; t < NT; t++)
      if (m_en[t] && ((v & m_mask[t]) == (m_val[t] & m_mask[t]))) r = r | m_or[t];
    return r;
  endfunction

  // Scoreboard: push at input accept, pop at output accept; reset flushes the model.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      for (int t = 0; t < NT; t++) m_en[t] = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sbq.size() == 0) chk("sb_unexpected_out", {48'd0, z}, 64'hdead);
        else chk("scoreboard", {48'd0, z}, {48'd0, sbq.pop_front()});
      end
      if (in_valid && in_ready) sbq.push_back(model(xv));
      if (cfg_valid && cfg_ready && cfg_addr < AW'(NT)) begin
        m_en[cfg_addr[4:0]]   = cfg_en;
        m_mask[cfg_addr[4:0]] = cfg_mask;
        m_val[cfg_addr[4:0]]  = cfg_val;
        m_or[cfg_addr[4:0]]   = cfg_or;
      end
    end
  end

  always @(posedge clk) if (rand_rdy) begin #1; out_ready = 1'($urandom_range(0, 1)); end

  task automatic tick; @(posedge clk); #1; endtask

  task automatic send(input logic [7:0] v);
    bit ok = 1'b0;
    in_valid = 1'b1; xv = v;
    for (int k = 0; k < 50 && !ok; k++) begin @(negedge clk); ok = in_ready; tick(); end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic e, input logic [7:0] m,
                           input logic [7:0] v, input logic [15:0] o, output bit ok);
    ok = 1'b0;
    cfg_valid = 1'b1; cfg_addr = a; cfg_en = e; cfg_mask = m; cfg_val = v; cfg_or = o;
    for (int k = 0; k < 50 && !ok; k++) begin @(negedge clk); ok = cfg_ready; tick(); end
    cfg_valid = 1'b0;
    if (!ok) chk("cfg_timeout", 0, 1);
  endtask

  task automatic expect_out(input logic [15:0] e, input string nm);
    bit got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin got = 1'b1; chk(nm, {48'd0, z}, {48'd0, e}); end
      tick();
    end
    if (!got) chk({nm, "_timeout"}, 0, 1);
  endtask

  typedef struct { logic [7:0] x; logic [15:0] z; } vec_t;
  vec_t tbl[8];

  initial begin
    bit ok;
    int n0, sent;
    bit acc;
    tbl[0] = '{8'h01, 16'h8001}; tbl[1] = '{8'h03, 16'h8000};
    tbl[2] = '{8'hA1, 16'h8103}; tbl[3] = '{8'hA5, 16'h8103};
    tbl[4] = '{8'h3C, 16'h8001}; tbl[5] = '{8'h3D, 16'h8001};
    tbl[6] = '{8'hAE, 16'h8102}; tbl[7] = '{8'hFF, 16'h8000};

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1); chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_out_valid", out_valid, 0); chk("rst_z", z, 0); chk("rst_cfg_err", cfg_err, 0);
    tick();

    // Empty PLA: zero output, two-cycle latency.
    send(8'hA5);
    @(negedge clk); chk("lat_n1_out_valid", out_valid, 0);
    tick();
    @(negedge clk); chk("lat_n2_out_valid", out_valid, 1); chk("lat_n2_z", z, 0);
    tick();

    cfg_write(6'd0, 1'b1, 8'h03, 8'h01, 16'h0001, ok);
    send(8'h01); expect_out(16'h0001, "t0_hit");
    send(8'h03); expect_out(16'h0000, "t0_miss");

    cfg_write(6'd1, 1'b1, 8'hF0, 8'hA0, 16'h0102, ok);
    cfg_write(6'd2, 1'b1, 8'h00, 8'h5A, 16'h8000, ok);
    cfg_write(6'd3, 1'b1, 8'hFF, 8'h3C, 16'h0001, ok);
    foreach (tbl[i]) begin send(tbl[i].x); expect_out(tbl[i].z, "table"); end

    // Stall: output holds, config blocked.
    out_ready = 1'b0;
    send(8'hA1);
    repeat (3) tick();
    @(negedge clk); chk("stall_valid", out_valid, 1); chk("stall_z", z, 16'h8103);
    chk("stall_cfg_ready", cfg_ready, 0);
    tick();
    @(negedge clk); chk("stall_hold_z", z, 16'h8103);
    tick();
    out_ready = 1'b1;
    expect_out(16'h8103, "stall_release");

    // Simultaneous config and input: config wins, input follows with the new term.
    cfg_valid = 1'b1; cfg_addr = 6'd4; cfg_en = 1'b1; cfg_mask = 8'hFF; cfg_val = 8'h5A; cfg_or = 16'h4000;
    in_valid = 1'b1; xv = 8'h5A;
    @(negedge clk); chk("coll_cfg_ready", cfg_ready, 1); chk("coll_in_ready", in_ready, 0);
    tick(); cfg_valid = 1'b0;
    @(negedge clk); chk("coll_in_next", in_ready, 1);
    tick(); in_valid = 1'b0;
    expect_out(16'hC000, "coll_new_term");

    // Out-of-range address.
    cfg_write(6'd32, 1'b1, 8'h00, 8'h00, 16'hFFFF, ok);
    chk("oor_handshake", ok, 1);
    @(negedge clk); chk("oor_err", cfg_err, 1);
    tick();
    send(8'hFF); expect_out(16'h8000, "oor_terms_unchanged");

    // Random full load and back-to-back stream under random backpressure.
    for (int t = 0; t < NT; t++)
      cfg_write(6'(t), 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 16'($urandom), ok);
    n0 = n_out; sent = 0; rand_rdy = 1'b1;
    in_valid = 1'b1; xv = 8'($urandom);
    for (int c = 0; c < 5000 && sent < 256; c++) begin
      @(negedge clk); acc = in_ready;
      tick();
      if (acc) begin sent++; xv = 8'($urandom); end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 3000 && sbq.size() != 0; c++) tick();
    rand_rdy = 1'b0; tick(); out_ready = 1'b1;
    chk("stream_sent", sent, 256);
    chk("stream_count", n_out - n0, 256);
    chk("stream_drain", sbq.size(), 0);
    chk("stream_err_sticky", cfg_err, 1);

    // Reset with two vectors in flight.
    in_valid = 1'b1; xv = 8'h11; tick();
    xv = 8'h22; tick();
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); chk("pre_rst_inflight", out_valid, 1);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0); chk("post_rst_z", z, 0);
    chk("post_rst_err", cfg_err, 0); chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_cfg_ready", cfg_ready, 1);
    tick();
    send(8'h01); expect_out(16'h0000, "post_rst_disabled");
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pla_engine.md
PLA_ENGINE -- requirements
Module: pla_engine

Interface
REQ-001 Parameter N_IN, default 8: input vector width (1..32).
REQ-002 Parameter N_TERM, default 32: product-term count (1..256).
REQ-003 Parameter N_OUT, default 16: output vector width (1..64).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cfg_valid  in  1  term-write request.
REQ-007 cfg_ready  out  1  term-write accept.
REQ-008 cfg_addr  in  clog2(N_TERM) (min 1)  term index.
REQ-009 cfg_en  in  1  term enable.
REQ-010 cfg_mask  in  N_IN  AND-plane care mask (1 = input used).
REQ-011 cfg_val  in  N_IN  AND-plane literal polarity (1 = true, 0 = complemented).
REQ-012 cfg_or  in  N_OUT  OR-plane connection of this term to each output.
REQ-013 cfg_err  out  1  sticky out-of-range address flag.
REQ-014 in_valid / in_ready  in / out  1 / 1  input handshake.
REQ-015 x  in  N_IN  input vector.
REQ-016 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-017 z  out  N_OUT  output vector.

Function
REQ-018 Term t SHALL be active iff en[t] and ((x & mask[t]) == (val[t] & mask[t])); an enabled all-zero mask SHALL be always active.
REQ-019 z[j] SHALL equal the OR, over all t, of active[t] & or[t][j]; no active terms SHALL give z = 0.
REQ-020 Pipeline SHALL be two stages: stage 1 registers the N_TERM active vector plus v1; stage 2 registers z plus out_valid.
REQ-021 With no stall, x accepted in cycle N SHALL appear with out_valid=1 in cycle N+2; sustained throughput SHALL be one vector per cycle.
REQ-022 Stage 2 SHALL be free when !out_valid || out_ready; stage 1 SHALL be free when !v1 || stage 2 free; in_ready = stage 1 free && !(cfg_valid && cfg_ready).
REQ-023 While out_valid && !out_ready, z and out_valid SHALL hold and no data SHALL be lost or duplicated.
REQ-024 cfg_ready SHALL be 1 only when v1 = 0 and out_valid = 0 (pipeline empty).
REQ-025 When cfg_valid and in_valid are both asserted and cfg_ready = 1, the config write SHALL win and in_ready SHALL be 0 that cycle.
REQ-026 An accepted write SHALL update en/mask/val/or of term cfg_addr at that edge and SHALL affect all inputs accepted from the next cycle on.
REQ-027 cfg_addr >= N_TERM SHALL complete the handshake, drop the write, and set cfg_err = 1 until reset.

Reset
REQ-028 rst SHALL clear every en bit, v1, out_valid, z, and cfg_err to 0; mask, val, and or SHALL need no reset.
REQ-029 rst during operation SHALL discard in-flight vectors; out_valid SHALL be 0 in the first cycle after rst.
REQ-030 in_ready and cfg_ready SHALL both be 1 in the first cycle after rst is deasserted, provided cfg_valid = 0.

Configuration
REQ-031 With PLA_ENGINE_PARITY_EN defined, the block SHALL add output z_par (1 bit) = XOR of z, registered with z, reset 0, and holding under stall.
REQ-032 Without PLA_ENGINE_PARITY_EN, port z_par and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-033 Package pla_engine_pkg SHALL hold the default N_IN/N_TERM/N_OUT constants and a parameterised term-record typedef {en, mask, val, or}.
REQ-034 Term storage and the write/err logic SHALL be sub-module pla_term_store; pla_engine SHALL hold the handshakes and both pipeline stages.

Verification
REQ-035 Reset, then in_valid with x=8'hA5 -> z=16'h0000 with out_valid in cycle N+2.
REQ-036 Write t0 {en=1, mask=8'h03, val=8'h01, or=16'h0001}; send x=8'h01 then 8'h03 -> z=16'h0001, then 16'h0000.
REQ-037 Load the 8-in/16-out defaults, stream 256 back-to-back inputs, apply random out_ready -> results match the golden model in order, none dropped.
REQ-038 cfg_valid and in_valid asserted together on an empty pipeline -> config accepted, in_ready=0 that cycle, input accepted next cycle using the new term.
REQ-039 cfg_addr=N_TERM (N_TERM=32, addr 6'd32 with widened bench) -> handshake completes, cfg_err=1, stored terms unchanged; rst -> cfg_err=0.
REQ-040 rst asserted with two vectors in flight -> out_valid=0 next cycle; all terms disabled, so z=0.
